// File: rtl/skel_pkg.sv
// rtl/skel_pkg.sv - shared skeletonization constants and frame streamer state type
package skel_pkg;

  localparam int FRAME_N     = 8;
  localparam int BIT_SIZE    = 6;
  localparam int PIXEL_WIDTH = 8;
  localparam int NPIX        = FRAME_N * FRAME_N;
  localparam int SLOT_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WRITE,
    GAP,
    READ,
    FIN
  } stream_state_t;

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - two-cycle slot phase toggle and slot index counter with terminal flag
module slot_timer
  import skel_pkg::*;
#(
  parameter int W    = BIT_SIZE + 1,
  parameter int LAST = NPIX - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         count,
  input  logic         freeze,
  output logic         ph,
  output logic [W-1:0] idx,
  output logic         last
);

  logic slot_end;

  assign last     = (idx == W'(LAST));
  assign slot_end = (ph == 1'(SLOT_CYCLES - 1));

  // The index wraps to 0 after the terminal slot so the next pass starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph  <= 1'b0;
      idx <= '0;
    end else if (!run) begin
      ph  <= 1'b0;
      idx <= '0;
    end else if (!freeze) begin
      ph <= ~ph;
      if (count && slot_end) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - frame write/read pass sequencer onto the shared pixel bus (optional HOLD_EN freeze input)
module frame_streamer
  import skel_pkg::*;
#(
  parameter int N          = FRAME_N,
  parameter int bitSize    = BIT_SIZE,
  parameter int pixelWidth = PIXEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef HOLD_EN
  input  logic                  hold,
`endif
  input  logic                  start,
  output logic [bitSize:0]      mem_addr,
  input  logic [pixelWidth-1:0] mem_rdata,
  output logic [bitSize:0]      pix_addr,
  output logic [pixelWidth-1:0] pix_data,
  output logic                  we,
  output logic                  busy,
  output logic                  done
);

  localparam int              FRAME_PIX = N * N;
  localparam int              AW        = bitSize + 1;
  localparam logic [bitSize:0] LAST_ADDR = AW'(FRAME_PIX - 1);

  stream_state_t  state;
  logic           run;
  logic           count;
  logic           freeze;
  logic           ph;
  logic [bitSize:0] idx;
  logic           last;
  logic [bitSize:0] next_slot;
  logic [bitSize:0] next_fetch;

  assign run   = (state == PRIME) || (state == WRITE) || (state == GAP) || (state == READ);
  assign count = (state == WRITE) || (state == READ);

`ifdef HOLD_EN
  assign freeze = hold & run;
`else
  assign freeze = 1'b0;
`endif

  slot_timer #(
    .W    (AW),
    .LAST (FRAME_PIX - 1)
  ) u_slot_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .count  (count),
    .freeze (freeze),
    .ph     (ph),
    .idx    (idx),
    .last   (last)
  );

  // Slot being entered at the next boundary, and the prefetch address for the slot after it.
  always_comb begin
    next_slot  = '0;
    next_fetch = '0;
    if (state == WRITE) begin
      next_slot = idx + 1'b1;
    end
    next_fetch = (next_slot == LAST_ADDR) ? next_slot : next_slot + 1'b1;
  end

  // Bus outputs only move on ph=1 edges, so each slot is held for both phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_addr <= '0;
      pix_addr <= '0;
      pix_data <= '0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (!freeze) begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= PRIME;
            busy  <= 1'b1;
          end
        end
        PRIME: begin
          if (ph) begin
            state    <= WRITE;
            we       <= 1'b1;
            pix_addr <= '0;
            pix_data <= mem_rdata;
            mem_addr <= next_fetch;
          end
        end
        WRITE: begin
          if (ph) begin
            if (last) begin
              state    <= GAP;
              we       <= 1'b0;
              pix_addr <= '0;
              pix_data <= '0;
              mem_addr <= '0;
            end else begin
              pix_addr <= next_slot;
              pix_data <= mem_rdata;
              mem_addr <= next_fetch;
            end
          end
        end
        GAP: begin
          if (ph) begin
            state    <= READ;
            pix_addr <= '0;
          end
        end
        READ: begin
          if (ph) begin
            if (last) begin
              state    <= FIN;
              busy     <= 1'b0;
              done     <= 1'b1;
              pix_addr <= '0;
            end else begin
              pix_addr <= idx + 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
